// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: pad instruction,
// instruction field positions and the fetch FSM state encoding.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Instruction field positions, shared with the decoder side of the pipeline
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int IMM_BIT    = 11;
  localparam int RD_MSB     = 10;
  localparam int RD_LSB     = 8;
  localparam int RS1_MSB    = 7;
  localparam int RS1_LSB    = 5;
  localparam int RS2_MSB    = 4;
  localparam int RS2_LSB    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [3:0] getOpcode(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory port: the fetch unit issues paired-instruction requests,
// the memory accepts them and later returns both halfwords together.
interface fetch_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata1;
  logic [15:0] imem_rdata2;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata1, imem_rdata2
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata1, imem_rdata2
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue: pushes two entries at a time, pops zero to two,
// flush empties it. Callers guarantee pop never exceeds the current count.
module fetch_queue #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [15:0]   data1_i,
  input  logic [15:0]   data2_i,
  input  logic [1:0]    pop_i,
  output logic [15:0]   head0_o,
  output logic [15:0]   head1_o,
  output logic [CW-1:0] count_o
);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] headPtr_q, headPtr_d;
  logic [PW-1:0] tailPtr_q, tailPtr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    headPtr_d = headPtr_q + PW'(pop_i);
    tailPtr_d = push_i ? tailPtr_q + PW'(2) : tailPtr_q;
    count_d   = count_q + (push_i ? CW'(2) : CW'(0)) - CW'(pop_i);
    if (flush_i) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[tailPtr_q]          <= data1_i;
      mem_q[tailPtr_q + PW'(1)] <= data2_i;
    end
  end

  assign head0_o = mem_q[headPtr_q];
  assign head1_o = mem_q[headPtr_q + PW'(1)];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps one paired request in flight, buffers the
// returned instructions and presents the two oldest to the issue stage.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter logic [15:0] NOP   = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        stall_in,
  input  logic        single_in,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr1_o,
  output logic [15:0] instr2_o,
  output logic [15:0] pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q;
  logic [15:0]   fetchPc_q;
  logic [15:0]   headPc_q;
  logic [CW-1:0] count;
  logic [15:0]   head0;
  logic [15:0]   head1;
  logic [1:0]    popReq;
  logic [1:0]    pop;
  logic [CW:0]   freeSlots;
  logic          canFetch;
  logic          accept;
  logic          respValid;
  logic          push;

  // Free space counts this cycle's pop, so a request can go out the same
  // cycle the issue stage drains a full queue
  always_comb begin
    popReq = stall_in ? 2'd0 : (single_in ? 2'd1 : 2'd2);
    pop    = ({{(CW-2){1'b0}}, popReq} > count) ? count[1:0] : popReq;
    if (redirect_valid) begin
      pop = 2'd0;
    end
    freeSlots = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
    canFetch  = (state_q == IDLE) && !redirect_valid && (freeSlots >= (CW+1)'(2));
  end

  assign accept    = canFetch && imem.imem_ready;
  assign respValid = (state_q != IDLE) && imem.imem_rvalid;
  assign push      = (state_q == WAIT) && imem.imem_rvalid && !redirect_valid;

  assign imem.imem_req  = canFetch && !rst;
  assign imem.imem_addr = fetchPc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fetchPc_q <= '0;
      headPc_q  <= '0;
    end else if (redirect_valid) begin
      fetchPc_q <= redirect_pc;
      headPc_q  <= redirect_pc;
      state_q   <= ((state_q == IDLE) || respValid) ? IDLE : DISCARD;
    end else begin
      headPc_q <= headPc_q + 16'(pop);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            state_q   <= IDLE;
            fetchPc_q <= fetchPc_q + 16'd2;
          end
        end
        DISCARD: begin
          if (imem.imem_rvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) uQueue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data1_i (imem.imem_rdata1),
    .data2_i (imem.imem_rdata2),
    .pop_i   (pop),
    .head0_o (head0),
    .head1_o (head1),
    .count_o (count)
  );

  assign instr1_o = (redirect_valid || (count == '0))      ? NOP : head0;
  assign instr2_o = (redirect_valid || (count < CW'(2)))   ? NOP : head1;
  assign pc_o     = headPc_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction-queue entries (16-bit each, power of two, >=4).
REQ-002 SHALL have parameter NOP, default 16'h0000, pad/bubble instruction.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  fetch request for two consecutive instructions.
REQ-006 SHALL have port imem_addr  output  16  instruction (halfword) address of first instruction of the pair.
REQ-007 SHALL have port imem_ready  input  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  response data valid.
REQ-009 SHALL have ports imem_rdata1 / imem_rdata2  input  16 each  instructions at imem_addr and imem_addr+1.
REQ-010 SHALL have port stall_in  input  1  downstream relayer stall; consume nothing.
REQ-011 SHALL have port single_in  input  1  downstream issued single instruction; consume one.
REQ-012 SHALL have ports redirect_valid  input  1 and redirect_pc  input  16  branch/jump redirect.
REQ-013 SHALL have ports instr1_o / instr2_o  output  16 each  queue head and head+1 (NOP when absent).
REQ-014 SHALL have port pc_o  output  16  address of instr1_o.

Function
REQ-015 SHALL hold fetch_pc (next address to request), head_pc, and a circular queue with count 0..DEPTH.
REQ-016 SHALL drive instr1_o = head if count>=1 else NOP; instr2_o = head+1 if count>=2 else NOP; combinational from registered state.
REQ-017 SHALL force instr1_o, instr2_o to NOP in any cycle with redirect_valid=1.
REQ-018 SHALL compute pop = 0 if stall_in; else 1 if single_in; else 2; stall_in has priority over single_in.
REQ-019 SHALL clamp pop to number of non-NOP-padded entries presented (pop<=count); padding is never consumed.
REQ-020 SHALL advance head_pc by the clamped pop, modulo 2^16.
REQ-021 SHALL use FSM states IDLE, WAIT, DISCARD.
REQ-022 IDLE: assert imem_req with imem_addr=fetch_pc when free entries (DEPTH-count+pop) >= 2 and redirect_valid=0; on imem_ready go to WAIT; else remain IDLE.
REQ-023 WAIT: imem_req=0; on imem_rvalid push rdata1 then rdata2 (two entries), fetch_pc += 2 (wrap 16 bits), go IDLE.
REQ-024 SHALL allow at most one outstanding request; push and pop in the same cycle SHALL both take effect, count += 2 - pop.
REQ-025 On redirect_valid (any state): queue cleared (count=0), fetch_pc and head_pc = redirect_pc, pop ignored; from WAIT go DISCARD unless imem_rvalid same cycle (data dropped, go IDLE); from IDLE, any handshake that cycle suppressed, go IDLE.
REQ-026 DISCARD: imem_req=0; on imem_rvalid drop data, go IDLE; further redirect_valid updates PCs, stays DISCARD.
REQ-027 SHALL never overflow: a request is issued only when two entries are guaranteed free at response time.
REQ-028 Queue wrap-around SHALL be transparent: indices modulo DEPTH, head+1 taken modulo DEPTH.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, fetch_pc=head_pc=16'h0000, count=0, pointers=0; outputs imem_req=0 while rst high, instr1_o=instr2_o=NOP, pc_o=0.
REQ-030 Reset mid-WAIT SHALL abandon the outstanding request; the first post-reset cycle SHALL be in IDLE with no discard pending.

Structure
REQ-031 SHALL place NOP, instruction field positions (opcode [15:12], imm flag [11], rd [10:8], rs1 [7:5], rs2 [4:2]) and the FSM state encoding in shared package fetch_pkg.
REQ-032 SHALL instantiate one sub-module fetch_queue (circular buffer: push-2, pop-0/1/2, flush, count); FSM and PC logic in fetch_unit.

Verification
REQ-033 Reset, imem_ready=1, rvalid one cycle after accept, data 0x1234/0x2345 -> imem_addr=0, then instr1_o=0x1234, instr2_o=0x2345, pc_o=0, next request addr 2.
REQ-034 Queue holding 4 entries, stall_in=1 for 3 cycles -> outputs and pc_o unchanged; single_in=1 next cycle -> instr1_o = former instr2_o, pc_o += 1.
REQ-035 Fill to DEPTH=8 with stall_in=1 -> imem_req stays 0 while free<2; release stall (pop 2) -> request issued that cycle.
REQ-036 redirect_valid=1, redirect_pc=0x0040 while in WAIT -> outputs NOP that cycle, following rvalid data discarded, next imem_addr=0x0040.
REQ-037 fetch_pc=0xFFFE response -> fetch_pc wraps to 0x0000; head_pc 0xFFFF with pop=2 -> pc_o=0x0001.
REQ-038 count=1 with pop request 2 -> one entry consumed, instr2_o=NOP, count=0, no underflow.
